// File: rtl/id_hazard_ctl_pkg.sv
// +----------------------------------------------------------------------+
// | id_hazard_ctl_pkg : opcodes and FSM state shared by the hazard unit  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package id_hazard_ctl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_LW    = 6'h23;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } hz_state_e;

   // Instructions that read rt as a source operand.
   function automatic logic uses_rt(input logic [5:0] opcode);
      return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
   endfunction

endpackage

`default_nettype wire

// File: rtl/id_hazard_ctl_sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter : saturating event counter with synchronous clear        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/id_hazard_ctl.sv
// +----------------------------------------------------------------------+
// | id_hazard_ctl : decode-stage load-use stall / branch flush control   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module id_hazard_ctl
   import id_hazard_ctl_pkg::*;
#(
   parameter int LU_STALL_CYCLES = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      IF_ID_instruction_out,
   input  logic             ID_EX_mem_read,
   input  logic [4:0]       ID_EX_rt,
   input  logic             EX_MEM_branch_taken,
   input  logic             mem_wait,
   input  logic             cnt_clr,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_bubble,
   output logic             id_ex_hold,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);

   hz_state_e  state_q, state_d;
   logic [2:0] stall_q, stall_d;

   logic [5:0] opcode;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       lu_hit;
   logic       unused_imm;

   assign opcode     = IF_ID_instruction_out[31:26];
   assign rs         = IF_ID_instruction_out[25:21];
   assign rt         = IF_ID_instruction_out[20:16];
   assign unused_imm = ^IF_ID_instruction_out[15:0];

   assign lu_hit = ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
                   ((ID_EX_rt == rs) || (uses_rt(opcode) && (ID_EX_rt == rt)));

   // rst_n gates the Mealy outputs so an asserted reset yields RUN values at once.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      id_ex_hold   = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      state_d      = state_q;
      stall_d      = stall_q;
      if (!rst_n) begin
         state_d = RUN;
         stall_d = 3'd0;
      end else if (EX_MEM_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         state_d      = RUN;
         stall_d      = 3'd0;
      end else if (mem_wait) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_hold  = 1'b1;
      end else if (state_q == LU_STALL) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         stall_d      = stall_q - 3'd1;
         if (stall_q == 3'd1) begin
            state_d = RUN;
         end
      end else if (lu_hit) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         // A single bubble clears ID_EX_mem_read, so no extra state is needed.
         if (LU_STALL_CYCLES > 1) begin
            state_d = LU_STALL;
            stall_d = LU_INIT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         stall_q <= 3'd0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~pc_write),
      .clr   (cnt_clr),
      .cnt   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (EX_MEM_branch_taken),
      .clr   (cnt_clr),
      .cnt   (flush_cnt)
   );

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_ctl.sv
// +----------------------------------------------------------------------+
// | tb_id_hazard_ctl : scoreboard bench, LU=1/CNT_W=16 and LU=3/CNT_W=4  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_id_hazard_ctl;

   typedef struct {
      logic [31:0] instr;
      logic        mr;
      logic [4:0]  rt;
      logic        bt;
      logic        mw;
      logic        clr;
   } stim_t;

   typedef struct {
      logic [6:0]  c0;
      logic [6:0]  c1;
      logic [15:0] sc0;
      logic [15:0] fc0;
      logic [3:0]  sc1;
      logic [3:0]  fc1;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        mr = 1'b0;
   logic [4:0]  idrt = 5'd0;
   logic        bt = 1'b0;
   logic        mw = 1'b0;
   logic        clr = 1'b0;

   logic        a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf;
   logic        b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf;
   logic [15:0] a_sc, a_fc;
   logic [3:0]  b_sc, b_fc;

   int n_chk = 0;
   int n_fail = 0;
   exp_t q[$];

   int m_state[2] = '{0, 0};
   int m_cnt[2]   = '{0, 0};
   int m_sc[2]    = '{0, 0};
   int m_fc[2]    = '{0, 0};

   always #5 clk = ~clk;

   id_hazard_ctl #(.LU_STALL_CYCLES(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .IF_ID_instruction_out(instr),
      .ID_EX_mem_read(mr), .ID_EX_rt(idrt), .EX_MEM_branch_taken(bt),
      .mem_wait(mw), .cnt_clr(clr),
      .pc_write(a_pcw), .if_id_write(a_ifw), .id_ex_bubble(a_bub),
      .id_ex_hold(a_hold), .if_id_flush(a_iff), .id_ex_flush(a_idf),
      .ex_mem_flush(a_exf), .stall_cnt(a_sc), .flush_cnt(a_fc)
   );

   id_hazard_ctl #(.LU_STALL_CYCLES(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .IF_ID_instruction_out(instr),
      .ID_EX_mem_read(mr), .ID_EX_rt(idrt), .EX_MEM_branch_taken(bt),
      .mem_wait(mw), .cnt_clr(clr),
      .pc_write(b_pcw), .if_id_write(b_ifw), .id_ex_bubble(b_bub),
      .id_ex_hold(b_hold), .if_id_flush(b_iff), .id_ex_flush(b_idf),
      .ex_mem_flush(b_exf), .stall_cnt(b_sc), .flush_cnt(b_fc)
   );

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
      return {op, rs, rt, 16'h1234};
   endfunction

   function automatic stim_t mk_s(input logic [31:0] i, input logic m, input logic [4:0] r,
                                  input logic b, input logic w, input logic c);
      stim_t s;
      s.instr = i; s.mr = m; s.rt = r; s.bt = b; s.mw = w; s.clr = c;
      return s;
   endfunction

   function automatic logic hit();
      logic [5:0] op;
      logic       u;
      op = instr[31:26];
      u  = (op == 6'h00) || (op == 6'h04) || (op == 6'h2B);
      return mr && (idrt != 5'd0) && ((idrt == instr[25:21]) || (u && (idrt == instr[20:16])));
   endfunction

   function automatic int lu_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int max_of(input int k);
      return (k == 0) ? 65535 : 15;
   endfunction

   // {pc_write, if_id_write, bubble, hold, if_id_flush, id_ex_flush, ex_mem_flush}
   function automatic logic [6:0] exp_ctl(input int k);
      if (!rst_n) return 7'b1100000;
      if (bt) return 7'b1100111;
      if (mw) return 7'b0001000;
      if ((m_state[k] == 1) || hit()) return 7'b0010000;
      return 7'b1100000;
   endfunction

   // Reference model of both instances, advanced on the same edges as the DUTs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_state[k] <= 0; m_cnt[k] <= 0; m_sc[k] <= 0; m_fc[k] <= 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (clr) m_sc[k] <= 0;
            else if (((exp_ctl(k) & 7'b1000000) == 7'd0) && (m_sc[k] != max_of(k))) m_sc[k] <= m_sc[k] + 1;
            if (clr) m_fc[k] <= 0;
            else if (bt && (m_fc[k] != max_of(k))) m_fc[k] <= m_fc[k] + 1;
            if (bt) begin
               m_state[k] <= 0; m_cnt[k] <= 0;
            end else if (!mw) begin
               if (m_state[k] == 1) begin
                  m_cnt[k] <= m_cnt[k] - 1;
                  if (m_cnt[k] == 1) m_state[k] <= 0;
               end else if (hit() && (lu_of(k) > 1)) begin
                  m_state[k] <= 1; m_cnt[k] <= lu_of(k) - 1;
               end
            end
         end
      end
   end

   task automatic drive(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      instr = s.instr; mr = s.mr; idrt = s.rt; bt = s.bt; mw = s.mw; clr = s.clr;
      #1;
      e.c0  = exp_ctl(0);
      e.c1  = exp_ctl(1);
      e.sc0 = 16'(m_sc[0]);
      e.fc0 = 16'(m_fc[0]);
      e.sc1 = 4'(m_sc[1]);
      e.fc1 = 4'(m_fc[1]);
      q.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      instr = mk_i(6'h00, 5'd2, 5'd3); mr = 1'b1; idrt = 5'd2; bt = 1'b0; mw = 1'b0; clr = 1'b0;
      #2;
      n_chk++;
      if ({a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf} !== 7'b1100000) begin
         n_fail++; $display("FAIL reset_ctl_a got %b exp %b", {a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf}, 7'b1100000);
      end
      n_chk++;
      if ({b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf} !== 7'b1100000) begin
         n_fail++; $display("FAIL reset_ctl_b got %b exp %b", {b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, 7'b1100000);
      end
      n_chk++;
      if ({a_sc, a_fc, b_sc, b_fc} !== 40'd0) begin
         n_fail++; $display("FAIL reset_cnt got %h exp 0", {a_sc, a_fc, b_sc, b_fc});
      end
      mr = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk_s(mk_i(6'h00, 5'd5, 5'd6), 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
      t.push_back(mk_s(mk_i(6'h00, 5'd2, 5'd3), 1'b1, 5'd2, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) t.push_back(mk_s(mk_i(6'h00, 5'd2, 5'd3), 1'b0, 5'd2, 1'b0, 1'b0, 1'b0));
      foreach (t[i]) begin
         drive(t[i]);
         e = q.pop_front();
         n_chk++;
         if ({a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf} !== e.c0) begin
            n_fail++; $display("FAIL load_use ctl_a row %0d got %b exp %b", i, {a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf}, e.c0);
         end
         n_chk++;
         if ({b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf} !== e.c1) begin
            n_fail++; $display("FAIL load_use ctl_b row %0d got %b exp %b", i, {b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, e.c1);
         end
      end
      n_chk++;
      if ({a_sc, b_sc} !== {16'd1, 4'd3}) begin
         n_fail++; $display("FAIL load_use stall_cnt got a=%0d b=%0d exp a=1 b=3", a_sc, b_sc);
      end
   endtask

   task automatic test_reg_filter();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk_s(mk_i(6'h00, 5'd0, 5'd0), 1'b1, 5'd0, 1'b0, 1'b0, 1'b1));
      t.push_back(mk_s(mk_i(6'h08, 5'd5, 5'd2), 1'b1, 5'd2, 1'b0, 1'b0, 1'b0));
      t.push_back(mk_s(mk_i(6'h23, 5'd3, 5'd2), 1'b1, 5'd2, 1'b0, 1'b0, 1'b0));
      t.push_back(mk_s(mk_i(6'h2B, 5'd5, 5'd2), 1'b1, 5'd2, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) t.push_back(mk_s(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
      t.push_back(mk_s(mk_i(6'h04, 5'd1, 5'd7), 1'b1, 5'd7, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) t.push_back(mk_s(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
      foreach (t[i]) begin
         drive(t[i]);
         e = q.pop_front();
         n_chk++;
         if ({a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf} !== e.c0) begin
            n_fail++; $display("FAIL reg_filter ctl_a row %0d got %b exp %b", i, {a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf}, e.c0);
         end
         n_chk++;
         if ({b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf} !== e.c1) begin
            n_fail++; $display("FAIL reg_filter ctl_b row %0d got %b exp %b", i, {b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, e.c1);
         end
         n_chk++;
         if ({a_sc, a_fc} !== {e.sc0, e.fc0}) begin
            n_fail++; $display("FAIL reg_filter cnt_a row %0d got %0d/%0d exp %0d/%0d", i, a_sc, a_fc, e.sc0, e.fc0);
         end
      end
   endtask

   task automatic test_branch_abort();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk_s(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
      t.push_back(mk_s(mk_i(6'h00, 5'd2, 5'd3), 1'b1, 5'd2, 1'b0, 1'b0, 1'b0));
      t.push_back(mk_s(mk_i(6'h00, 5'd2, 5'd3), 1'b0, 5'd2, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) t.push_back(mk_s(mk_i(6'h00, 5'd2, 5'd3), 1'b0, 5'd2, 1'b0, 1'b0, 1'b0));
      foreach (t[i]) begin
         drive(t[i]);
         e = q.pop_front();
         n_chk++;
         if ({b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf} !== e.c1) begin
            n_fail++; $display("FAIL branch_abort ctl_b row %0d got %b exp %b", i, {b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, e.c1);
         end
         n_chk++;
         if ({b_sc, b_fc} !== {e.sc1, e.fc1}) begin
            n_fail++; $display("FAIL branch_abort cnt_b row %0d got %0d/%0d exp %0d/%0d", i, b_sc, b_fc, e.sc1, e.fc1);
         end
      end
      n_chk++;
      if ({a_fc, b_fc, b_sc} !== {16'd1, 4'd1, 4'd1}) begin
         n_fail++; $display("FAIL branch_abort totals got fa=%0d fb=%0d sb=%0d exp 1 1 1", a_fc, b_fc, b_sc);
      end
   endtask

   task automatic test_mem_wait();
      stim_t t[$];
      exp_t  e;
      t.push_back(mk_s(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
      t.push_back(mk_s(mk_i(6'h00, 5'd9, 5'd4), 1'b1, 5'd4, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) t.push_back(mk_s(mk_i(6'h00, 5'd9, 5'd4), 1'b0, 5'd4, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < 4; i++) t.push_back(mk_s(mk_i(6'h00, 5'd9, 5'd4), 1'b0, 5'd4, 1'b0, 1'b0, 1'b0));
      foreach (t[i]) begin
         drive(t[i]);
         e = q.pop_front();
         n_chk++;
         if ({a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf} !== e.c0) begin
            n_fail++; $display("FAIL mem_wait ctl_a row %0d got %b exp %b", i, {a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf}, e.c0);
         end
         n_chk++;
         if ({b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf} !== e.c1) begin
            n_fail++; $display("FAIL mem_wait ctl_b row %0d got %b exp %b", i, {b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, e.c1);
         end
      end
      n_chk++;
      if ({a_sc, b_sc} !== {16'd5, 4'd7}) begin
         n_fail++; $display("FAIL mem_wait stall_cnt got a=%0d b=%0d exp a=5 b=7", a_sc, b_sc);
      end
   endtask

   task automatic test_saturate_clear();
      stim_t t[$];
      exp_t  e;
      for (int i = 0; i < 20; i++) t.push_back(mk_s(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0));
      t.push_back(mk_s(mk_i(6'h00, 5'd2, 5'd3), 1'b1, 5'd2, 1'b1, 1'b0, 1'b0));
      t.push_back(mk_s(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
      foreach (t[i]) begin
         drive(t[i]);
         e = q.pop_front();
         n_chk++;
         if ({b_sc, b_fc} !== {e.sc1, e.fc1}) begin
            n_fail++; $display("FAIL saturate cnt_b row %0d got %0d/%0d exp %0d/%0d", i, b_sc, b_fc, e.sc1, e.fc1);
         end
         n_chk++;
         if ({a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf} !== e.c0) begin
            n_fail++; $display("FAIL saturate ctl_a row %0d got %b exp %b", i, {a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf}, e.c0);
         end
      end
      n_chk++;
      if (b_sc !== 4'hF) begin
         n_fail++; $display("FAIL saturate held got %h exp f", b_sc);
      end
      drive(mk_s(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
      void'(q.pop_front());
      drive(mk_s(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
      e = q.pop_front();
      n_chk++;
      if ({a_sc, a_fc, b_sc, b_fc} !== {e.sc0, e.fc0, e.sc1, e.fc1} || b_sc !== 4'd0) begin
         n_fail++; $display("FAIL cnt_clr got %h exp 0", {a_sc, a_fc, b_sc, b_fc});
      end
   endtask

   task automatic test_back_to_back();
      stim_t t[$];
      exp_t  e;
      for (int i = 0; i < 3; i++) t.push_back(mk_s(mk_i(6'h00, 5'd8, 5'd11), 1'b1, 5'd11, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) t.push_back(mk_s(mk_i(6'h00, 5'd8, 5'd11), 1'b0, 5'd11, 1'b0, 1'b0, 1'b0));
      foreach (t[i]) begin
         drive(t[i]);
         e = q.pop_front();
         n_chk++;
         if ({a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf, a_sc} !== {e.c0, e.sc0}) begin
            n_fail++; $display("FAIL back_to_back a row %0d got %b/%0d exp %b/%0d", i, {a_pcw, a_ifw, a_bub, a_hold, a_iff, a_idf, a_exf}, a_sc, e.c0, e.sc0);
         end
         n_chk++;
         if ({b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf, b_sc} !== {e.c1, e.sc1}) begin
            n_fail++; $display("FAIL back_to_back b row %0d got %b/%0d exp %b/%0d", i, {b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, b_sc, e.c1, e.sc1);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      exp_t e;
      drive(mk_s(mk_i(6'h00, 5'd2, 5'd3), 1'b1, 5'd2, 1'b0, 1'b0, 1'b0));
      void'(q.pop_front());
      drive(mk_s(mk_i(6'h00, 5'd2, 5'd3), 1'b0, 5'd2, 1'b0, 1'b0, 1'b0));
      e = q.pop_front();
      n_chk++;
      if (b_pcw !== e.c1[6] || e.c1[6] !== 1'b0) begin
         n_fail++; $display("FAIL mid_stall pre_reset pc_write got %b exp 0", b_pcw);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf} !== 7'b1100000) begin
         n_fail++; $display("FAIL mid_stall reset ctl_b got %b exp %b", {b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, 7'b1100000);
      end
      n_chk++;
      if ({a_sc, b_sc} !== 20'd0) begin
         n_fail++; $display("FAIL mid_stall reset cnt got a=%0d b=%0d exp 0", a_sc, b_sc);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(mk_s(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
      e = q.pop_front();
      n_chk++;
      if ({b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf} !== e.c1) begin
         n_fail++; $display("FAIL mid_stall after ctl_b got %b exp %b", {b_pcw, b_ifw, b_bub, b_hold, b_iff, b_idf, b_exf}, e.c1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_use();
      test_reg_filter();
      test_branch_abort();
      test_mem_wait();
      test_saturate_clear();
      test_back_to_back();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/id_hazard_ctl.md
Name: id_hazard_ctl

Overview:
- Hazard and stall controller for the decode stage.
- Watches the instruction held in IF/ID, the load in ID/EX and branch resolution in EX/MEM.
- Drives the PC and IF/ID write enables, inserts bubbles into ID/EX and flushes wrong-path stages.
- Keeps saturating stall and flush statistics counters for the pipeline testbenches.

Parameters:
- LU_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (legal 1..7).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_ID_instruction_out  in  32  instruction in IF/ID; uses opcode [31:26], rs [25:21], rt [20:16].
- ID_EX_mem_read  in  1  instruction in ID/EX is a load.
- ID_EX_rt  in  5  destination register of that load.
- EX_MEM_branch_taken  in  1  branch resolved taken in MEM this cycle.
- mem_wait  in  1  data memory not ready; freezes the whole front end.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID may load.
- id_ex_bubble  out  1  zero WB/M/EX control fields entering ID/EX.
- id_ex_hold  out  1  ID/EX keeps its contents (mem_wait freeze).
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  clear the stage to a NOP.
- stall_cnt  out  CNT_W  cycles with pc_write=0.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- During reset: state = RUN, stall counter = 0, stall_cnt = 0, flush_cnt = 0.
- During reset the combinational outputs read pc_write=1, if_id_write=1, all others 0.
- uses_rt = 1 for opcode 0x00 (R-type), 0x04 (beq) and 0x2B (sw); 0 otherwise.
- lu_hit = ID_EX_mem_read & (ID_EX_rt != 0) & ((ID_EX_rt == rs) | (uses_rt & ID_EX_rt == rt)).
- All control outputs are combinational from state and current inputs (zero-latency Mealy), so they take effect on the same edge.
- Priority, highest first: EX_MEM_branch_taken > mem_wait > load-use.
- Branch taken (any state):
  - if_id_flush = id_ex_flush = ex_mem_flush = 1, pc_write = 1, if_id_write = 1.
  - Next state is RUN and the stall counter is cleared; this aborts a load-use stall in progress.
- mem_wait = 1 (no branch):
  - pc_write = 0, if_id_write = 0, id_ex_hold = 1, id_ex_bubble = 0.
  - State and stall counter are frozen.
- State RUN with lu_hit:
  - pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
  - If LU_STALL_CYCLES > 1: next state LU_STALL, counter = LU_STALL_CYCLES-1. Otherwise stay RUN; the bubble clears ID_EX_mem_read, so no re-trigger.
- State RUN without lu_hit: pc_write = 1, if_id_write = 1, all others 0.
- State LU_STALL: outputs as a RUN lu_hit cycle, regardless of lu_hit. Counter decrements each cycle; when it reads 1, next state is RUN.
- Statistics counters:
  - stall_cnt increments on every cycle with pc_write = 0.
  - flush_cnt increments on every cycle with EX_MEM_branch_taken = 1.
  - Both saturate at all-ones.
  - cnt_clr takes priority over increment: counter reads 0 the next cycle.
- Register 0 never causes a hazard.
- Simultaneous lu_hit and branch: flush only; no stall is counted.
- rst_n asserted mid-stall: outputs return to RUN values immediately (asynchronous).

Decomposition:
- Shared package: opcode constants (OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_SW=6'h2B, OP_LW=6'h23) and the FSM state typedef {RUN, LU_STALL}. The control decoder already uses these opcodes.
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- lw $2 in ID/EX (ID_EX_rt=2), add rs=2 in IF/ID → one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle with mem_read=0 → pc_write=1; stall_cnt=1.
- LU_STALL_CYCLES=3, same hazard → exactly 3 bubble cycles, then RUN; stall_cnt=3.
- ID_EX_rt=0 or lw-dependent addi rt=2 (uses_rt=0) → no stall; sw with rt=2 → stall.
- Branch taken during cycle 2 of a 3-cycle stall → all three flushes in that cycle, pc_write=1, next cycle normal; flush_cnt=1.
- mem_wait=1 for 4 cycles mid LU_STALL → id_ex_hold=1 and counter frozen; stall resumes after; stall_cnt = 4 + stall cycles.
- Preload stall_cnt to 16'hFFFF → stays 16'hFFFF on further stall; cnt_clr → 0; rst_n low mid-stall → pc_write=1 combinationally.
